// File: rtl/dither_scheduler_if.sv
// Pixel-group input stream, dither-unit drive/return and packed output stream
// of the dither scheduler.
interface dither_scheduler_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dith_vin;
    logic [2:0]  dith_x;
    logic [2:0]  dith_y;
    logic [3:0]  dith_vout;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_valid, out_ready, dith_vout,
        input  in_ready, dith_vin, dith_x, dith_y, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready, dith_vout,
        output in_ready, dith_vin, dith_x, dith_y, out_data, out_valid
    );
endinterface

// File: rtl/dither_scheduler.sv
// Issues 4-pixel groups to a dither unit with position phases, then packs the
// returned 4-bit results into 16-bit words, four groups per word.
module dither_scheduler #(
    parameter string COLORMODE = "DES",
    parameter int    H_GROUPS  = 400,
    parameter int    V_LINES   = 1200
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              frame_start,
    dither_scheduler_if.slave bus,
    output logic              busy,
    output logic              frame_done
);
    localparam int CW = ($clog2(H_GROUPS) < 3) ? 3 : $clog2(H_GROUPS);
    localparam int LW = ($clog2(V_LINES) < 3) ? 3 : $clog2(V_LINES);
    localparam bit IS_DES = (COLORMODE == "DES");
    localparam logic [CW-1:0] COL_LAST  = CW'(H_GROUPS - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] col_r;
    logic [LW-1:0] line_r;
    logic [1:0]    phase_x_r;
    logic [1:0]    phase_y_r;
    logic [1:0]    issue_cnt_r;
    logic          issue_d_r;
    logic          last_d_r;
    logic [11:0]   pack_r;       // first three nibbles of the word being built
    logic [15:0]   out_data_r;
    logic          out_valid_r;
    logic          in_ready_s;
    logic          issue_s;
    logic          col_end_s;
    logic          frame_end_s;
    logic          drained_s;

    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Input acceptance: a word-completing issue waits while the output slot is blocked.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == ACTIVE) begin
            in_ready_s = !((issue_cnt_r == 2'd3) && out_valid_r && !bus.out_ready);
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign issue_s     = bus.in_valid && in_ready_s;
    assign col_end_s   = (col_r == COL_LAST);
    assign frame_end_s = issue_s && col_end_s && (line_r == LINE_LAST);
    assign drained_s   = !issue_d_r && !out_valid_r;

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (frame_start) state_s = ACTIVE;
                else             state_s = IDLE;
            end
            ACTIVE: begin
                if (frame_end_s) state_s = DRAIN;
                else             state_s = ACTIVE;
            end
            DRAIN: begin
                if (drained_s) state_s = IDLE;
                else           state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Position counters and dither phases; they only move on an issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_r       <= {CW{1'b0}};
            line_r      <= {LW{1'b0}};
            phase_x_r   <= 2'd0;
            phase_y_r   <= 2'd0;
            issue_cnt_r <= 2'd0;
        end else if ((state_r == IDLE) && frame_start) begin
            col_r       <= {CW{1'b0}};
            line_r      <= {LW{1'b0}};
            phase_x_r   <= 2'd0;
            phase_y_r   <= 2'd0;
            issue_cnt_r <= 2'd0;
        end else if (issue_s) begin
            issue_cnt_r <= issue_cnt_r + 2'd1;
            if (col_end_s) begin
                col_r     <= {CW{1'b0}};
                line_r    <= (line_r == LINE_LAST) ? {LW{1'b0}} : line_r + LW'(1);
                phase_x_r <= 2'd0;
                phase_y_r <= mod3_inc(phase_y_r);
            end else begin
                col_r     <= col_r + CW'(1);
                phase_x_r <= mod3_inc(phase_x_r);
            end
        end
    end

    // Result capture: the dither result arrives one cycle after the issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_d_r   <= 1'b0;
            last_d_r    <= 1'b0;
            pack_r      <= 12'd0;
            out_data_r  <= 16'd0;
            out_valid_r <= 1'b0;
        end else begin
            issue_d_r <= issue_s;
            last_d_r  <= issue_s && (issue_cnt_r == 2'd3);
            if (issue_d_r) begin
                pack_r <= {pack_r[7:0], bus.dith_vout};
            end
            // A completed word takes the slot even if the old one leaves this edge.
            if (issue_d_r && last_d_r) begin
                out_data_r  <= {pack_r, bus.dith_vout};
                out_valid_r <= 1'b1;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.dith_vin  = bus.in_data;
    assign bus.dith_x    = IS_DES ? {1'b0, phase_x_r} : col_r[2:0];
    assign bus.dith_y    = IS_DES ? {1'b0, phase_y_r} : line_r[2:0];
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = (state_r != IDLE);
    assign frame_done    = (state_r == DRAIN) && drained_s;
endmodule

// File: tb/tb_dither_scheduler.sv
// Directed bench for dither_scheduler: a DES and a MONO instance share stimulus;
// a scoreboard predicts packed words from the driven pixel data.
module tb_dither_scheduler;
    localparam int HG = 8;
    localparam int VL = 3;
    localparam int NG = HG * VL;

    logic clk = 1'b0;
    logic rstn;
    logic frame_start;
    logic busy_d, fd_d, busy_m, fd_m;

    dither_scheduler_if bus_d ();
    dither_scheduler_if bus_m ();

    dither_scheduler #(.COLORMODE("DES"), .H_GROUPS(HG), .V_LINES(VL)) dut_des (
        .clk(clk), .rstn(rstn), .frame_start(frame_start),
        .bus(bus_d.slave), .busy(busy_d), .frame_done(fd_d)
    );

    dither_scheduler #(.COLORMODE("MONO"), .H_GROUPS(HG), .V_LINES(VL)) dut_mono (
        .clk(clk), .rstn(rstn), .frame_start(frame_start),
        .bus(bus_m.slave), .busy(busy_m), .frame_done(fd_m)
    );

    always #5 clk = ~clk;

    // Dither unit stand-in: returns the low nibble of the drive one cycle later.
    always @(posedge clk) begin
        bus_d.dith_vout <= bus_d.dith_vin[3:0];
        bus_m.dith_vout <= bus_m.dith_vin[3:0];
    end

    int          n_tests;
    int          n_fail;
    int          g;
    int          nib;
    int          words;
    int          fd_cnt;
    int          cyc;
    int          first_issue;
    int          last_issue;
    logic [15:0] partial;
    logic [15:0] exp_q[$];
    logic [15:0] first_word;
    logic        have_first;
    logic        hold_pending;
    logic [15:0] hold_data;
    logic        prev_ov;
    logic        last_rdy;
    logic [2:0]  x_before;
    logic [2:0]  y_before;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at edge+1, sample at edge+3, return at next edge+1.
    task automatic cycle(input logic iv, input logic ordy, input logic fs);
        logic [31:0] d;
        logic [15:0] w;
        d      = $urandom();
        d[3:0] = 4'(g + 1);
        bus_d.in_data   = d;
        bus_m.in_data   = d;
        bus_d.in_valid  = iv;
        bus_m.in_valid  = iv;
        bus_d.out_ready = ordy;
        bus_m.out_ready = ordy;
        frame_start     = fs;
        #2;
        if (hold_pending) begin
            check("hold_valid", 32'(bus_d.out_valid), 32'd1);
            check("hold_data", 32'(bus_d.out_data), 32'(hold_data));
        end
        last_rdy = bus_d.in_ready;
        if (bus_d.in_valid && bus_d.in_ready) begin
            check("dith_vin", bus_d.dith_vin, d);
            check("des_x", 32'(bus_d.dith_x), 32'((g % HG) % 3));
            check("des_y", 32'(bus_d.dith_y), 32'((g / HG) % 3));
            check("mono_ready", 32'(bus_m.in_ready), 32'd1);
            check("mono_x", 32'(bus_m.dith_x), 32'(g % HG));
            check("mono_y", 32'(bus_m.dith_y), 32'(g / HG));
            partial = {partial[11:0], d[3:0]};
            nib++;
            if (nib == 4) begin
                exp_q.push_back(partial);
                nib = 0;
            end
            if (first_issue < 0) first_issue = cyc;
            last_issue = cyc;
            g++;
        end
        if (bus_d.out_valid && bus_d.out_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("sb_word", 32'(bus_d.out_data), 32'(w));
                check("mono_word", 32'(bus_m.out_data), 32'(w));
            end
            if (!have_first) begin
                first_word = bus_d.out_data;
                have_first = 1'b1;
            end
            words++;
        end
        if (fd_d) begin
            fd_cnt++;
            check("fd_after_valid", 32'(prev_ov), 32'd1);
            check("fd_valid_low", 32'(bus_d.out_valid), 32'd0);
        end
        prev_ov      = bus_d.out_valid;
        hold_pending = bus_d.out_valid && !bus_d.out_ready;
        hold_data    = bus_d.out_data;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        g           = 0;
        nib         = 0;
        words       = 0;
        fd_cnt      = 0;
        first_issue = -1;
        last_issue  = -1;
        have_first  = 1'b0;
        exp_q.delete();
        cycle(1'b0, 1'b1, 1'b1);
    endtask

    task automatic finish_frame(input bit rand_ready);
        for (int i = 0; i < 400 && fd_cnt == 0; i++) begin
            cycle(1'(g < NG), rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        end
        check("fd_seen", 32'(fd_cnt), 32'd1);
        check("issues", 32'(g), 32'(NG));
        check("words", 32'(words), 32'(NG / 4));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("busy_after", 32'(busy_d), 32'd0);
        check("fd_single", 32'(fd_cnt), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus_d.in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(bus_d.out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(bus_d.out_data), 32'd0);
        check({tag, "_busy"}, 32'(busy_d), 32'd0);
        check({tag, "_frame_done"}, 32'(fd_d), 32'd0);
        check({tag, "_dith_x"}, 32'(bus_d.dith_x), 32'd0);
        check({tag, "_dith_y"}, 32'(bus_d.dith_y), 32'd0);
        check({tag, "_mono_x"}, 32'(bus_m.dith_x), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        partial = 16'd0;
        hold_pending = 1'b0;
        hold_data = 16'd0;
        prev_ov = 1'b0;
        last_rdy = 1'b0;
        rstn = 1'b0;
        frame_start = 1'b0;
        bus_d.in_data = 32'd0;
        bus_m.in_data = 32'd0;
        bus_d.in_valid = 1'b0;
        bus_m.in_valid = 1'b0;
        bus_d.out_ready = 1'b1;
        bus_m.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Streaming frame with out_ready held high.
        start_frame();
        finish_frame(1'b0);
        check("consecutive", 32'(last_issue - first_issue), 32'(NG - 1));
        check("pack_1234", 32'(first_word), 32'h0000_1234);

        // Backpressure: the 8th group must wait for the first word to leave.
        start_frame();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0);
        check("bp_issues", 32'(g), 32'd7);
        check("bp_in_ready", 32'(last_rdy), 32'd0);
        check("bp_data", 32'(bus_d.out_data), 32'h0000_1234);
        finish_frame(1'b1);

        // Ignored frame_start while active, then asynchronous reset at group 10.
        start_frame();
        for (int i = 0; i < 40 && g < 5; i++) cycle(1'b1, 1'b1, 1'b0);
        x_before = bus_d.dith_x;
        y_before = bus_d.dith_y;
        cycle(1'b0, 1'b1, 1'b1);
        check("ign_busy", 32'(busy_d), 32'd1);
        check("ign_x", 32'(bus_d.dith_x), 32'(x_before));
        check("ign_y", 32'(bus_d.dith_y), 32'(y_before));
        for (int i = 0; i < 40 && g < 10; i++) cycle(1'b1, 1'b1, 1'b0);
        check("pre_reset_groups", 32'(g), 32'd10);
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        hold_pending = 1'b0;
        prev_ov = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check("post_reset_ready", 32'(last_rdy), 32'd0);
            check("post_reset_busy", 32'(busy_d), 32'd0);
        end
        start_frame();
        finish_frame(1'b0);
        check("restart_pack", 32'(first_word), 32'h0000_1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dither_scheduler.md
DITHER_SCHEDULER -- requirements
Module: dither_scheduler

Interface
REQ-001 SHALL have parameter COLORMODE, default "DES", selecting the position-phase sequence ("DES", "MONO" or "RGBW").
REQ-002 SHALL have parameter H_GROUPS, default 400: 4-pixel groups per line; a legal value is a multiple of 4 and ≥4.
REQ-003 SHALL have parameter V_LINES, default 1200: lines per frame; a legal value is ≥1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port frame_start, input, 1: single-cycle frame start request.
REQ-007 SHALL have ports in_data (input, 32), in_valid (input, 1) and in_ready (output, 1): the pixel-group stream, four 8-bit pixels with the first pixel in [31:24].
REQ-008 SHALL have ports dith_vin (output, 32), dith_x (output, 3) and dith_y (output, 3): the drive to the dither unit.
REQ-009 SHALL have port dith_vout, input, 4: dither unit result, valid exactly 1 cycle after drive.
REQ-010 SHALL have ports out_data (output, 16), out_valid (output, 1) and out_ready (input, 1): the packed output stream, 4 groups per word.
REQ-011 SHALL have port busy, output, 1: high whenever state ≠ IDLE.
REQ-012 SHALL have port frame_done, output, 1: single-cycle pulse at frame completion.

Function
REQ-013 SHALL implement the states IDLE, ACTIVE and DRAIN.
REQ-014 SHALL transition IDLE→ACTIVE on frame_start and clear col, line, phase and issue_cnt; frame_start SHALL be ignored in ACTIVE and DRAIN.
REQ-015 SHALL define issue as in_valid && in_ready in the same cycle; dith_vin SHALL equal in_data combinationally.
REQ-016 SHALL assert in_ready only in ACTIVE, and SHALL deassert it when issue_cnt==3 && out_valid && !out_ready (a word-completing issue is held until the output slot frees next cycle).
REQ-017 SHALL keep issue_cnt (2 bits), incrementing by 1 per issue and wrapping 3→0.
REQ-018 SHALL keep col in 0..H_GROUPS-1, incrementing per issue; at H_GROUPS-1 col SHALL wrap to 0 and line SHALL increment.
REQ-019 SHALL, when issuing with col==H_GROUPS-1 && line==V_LINES-1, transition to DRAIN in the next cycle.
REQ-020 SHALL, in DES mode, drive dith_x as a mod-3 phase (0,1,2,0…) advancing per issue and resetting to 0 at line start, and dith_y as a mod-3 phase advancing per line.
REQ-021 SHALL, in MONO and RGBW modes, drive dith_x = col[2:0] and dith_y = line[2:0].
REQ-022 SHALL keep dith_x/dith_y stable when no issue occurs.
REQ-023 SHALL register issue_d = issue, and SHALL shift dith_vout into the 16-bit pack register when issue_d is high; the first group of a word lands in [15:12].
REQ-024 SHALL, when the nibble issued with issue_cnt==3 lands, load out_data with the full word and set out_valid in the same edge.
REQ-025 SHALL clear out_valid on out_valid && out_ready unless a new word loads on the same edge, in which case out_valid stays 1 with the new data.
REQ-026 SHALL hold out_data/out_valid stable while out_valid && !out_ready; no word SHALL be dropped or duplicated.
REQ-027 SHALL transition DRAIN→IDLE when !issue_d && !out_valid, pulsing frame_done for exactly that one cycle.
REQ-028 SHALL give a throughput of 1 group/cycle with out_ready held high; issue→out_valid latency SHALL be 1 cycle for the 4th group of a word.

Reset
REQ-029 SHALL, on rstn low (asynchronous), force state=IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0, dith_x=0, dith_y=0, and clear all counters, issue_d and the pack register.
REQ-030 SHALL, on reset mid-frame, discard all in-flight and partial data; after rstn release the block SHALL idle until the next frame_start.

Verification (H_GROUPS=8, V_LINES=3, COLORMODE="DES" unless noted)
REQ-031 SHALL verify streaming: frame_start, in_valid and out_ready held 1 → 24 issues in 24 consecutive cycles, 6 words, frame_done one cycle after the last out_valid clears, busy low afterwards.
REQ-032 SHALL verify phases: dith_x sequence per line is 0,1,2,0,1,2,0,1, and dith_y is 0,1,2 over lines 0..2; with MONO, dith_x is 0..7 and dith_y is 0,1,2.
REQ-033 SHALL verify packing: dith_vout returns 0x1,0x2,0x3,0x4 for groups 0..3 → out_data=0x1234.
REQ-034 SHALL verify backpressure: out_ready=0 with a word pending → in_ready drops when issue_cnt==3, out_data stays constant, and no loss or duplication occurs after out_ready returns.
REQ-035 SHALL verify ignored start and mid-frame reset: frame_start pulsed in ACTIVE → no counter change; rstn low at group 10 → all outputs at reset values asynchronously, and the next frame starts from col=0, line=0.
